// File: rtl/regfile_dump_64.sv
// Debug read-out engine: walks the register file through one read port and
// emits a framed byte stream (header, index + data bytes per register, XOR checksum).
module regfile_dump_64 #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 64,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [4:0]        rd_reg,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     BYTES    = DATA_W / 8;
    localparam int unsigned     CNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [4:0]      IDX_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_IDX,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [4:0]        rd_reg_q, rd_reg_d;

    assign rd_reg = rd_reg_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            snap_q   <= '0;
            rd_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            snap_q   <= snap_d;
            rd_reg_q <= rd_reg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        snap_d   = snap_q;
        tx_data  = '0;
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) state_d = S_IDX;
            end
            S_IDX: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = {3'b000, idx_q};
                if (tx_ready) begin
                    // Register value is frozen here; later writes do not reach the stream.
                    snap_d  = rd_data;
                    csum_d  = csum_q ^ tx_data;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = snap_q[7:0];
                if (tx_ready) begin
                    csum_d = csum_q ^ tx_data;
                    snap_d = snap_q >> 8;
                    if (cnt_q == CNT_LAST) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = S_CSUM;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_IDX;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered read index tracks the index the next IDX state will present.
        rd_reg_d = (state_d == S_IDX) ? idx_d : '0;
    end

endmodule

// File: tb/tb_regfile_dump_64.sv
// Directed bench for regfile_dump_64: full dump, backpressure, snapshot,
// ignored starts and mid-frame reset, checked against a hand-built frame.
module tb_regfile_dump_64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  rd_reg;
    logic [63:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [63:0] rf [32];
    assign rd_data = rf[rd_reg];

    regfile_dump_64 #(
        .NUM_REGS(32),
        .DATA_W  (64),
        .HDR_BYTE(8'hA5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_reg  (rd_reg),
        .rd_data (rd_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] got [$];
    logic [7:0] exp [$];
    int   last_hs_cyc = 0;
    int   done_cyc = 0;
    int   done_count = 0;
    int   stall_viol = 0;
    int   rdreg_bad = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = '0;
    int   p;

    int   mode = 0;
    int   hold_left = 0;
    bit   hold_done = 0;
    bit   snap_arm = 0;
    bit   snap_pending = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Sink: always ready, random with a 6-cycle stall on byte 3, or idle.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                if (hold_left > 0) begin
                    tx_ready = 1'b0;
                    hold_left--;
                end else if (!hold_done && got.size() == 3 && tx_valid === 1'b1) begin
                    tx_ready  = 1'b0;
                    hold_left = 5;
                    hold_done = 1;
                end else begin
                    tx_ready = 1'($urandom_range(0, 1));
                end
            end
            default: tx_ready = 1'b1;
        endcase
    end

    always @(posedge clk) begin
        if (snap_pending) begin
            #1;
            rf[7] = 64'h1;
            snap_pending = 0;
        end
    end

    // Monitor: inputs are stable from posedge+1, so a negedge sample sees the next handshake.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_viol++;
            prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            prev_data  = tx_data;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                p = got.size();
                if (p >= 1 && p <= 288 && ((p - 1) % 9) == 0 && rd_reg !== tx_data[4:0]) rdreg_bad++;
                got.push_back(tx_data);
                last_hs_cyc = cyc;
                if (snap_arm && p == 64) begin
                    snap_pending = 1;
                    snap_arm = 0;
                end
            end
            if (done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic build_exp();
        logic [63:0] x5v;
        x5v = 64'hDEADBEEF_CAFEF00D;
        exp.delete();
        exp.push_back(8'hA5);
        for (int k = 0; k < 32; k++) begin
            exp.push_back(8'(k));
            for (int b = 0; b < 8; b++) exp.push_back((k == 5) ? x5v[8*b +: 8] : 8'h00);
        end
        exp.push_back(8'hEB);
    endtask

    task automatic check_frame(input string tag);
        int bad = 0;
        int first = -1;
        chk({tag, "_len"}, 64'(got.size()), 64'd290);
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (got[i] !== exp[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0) $display("first byte difference in %s at %0d: got %0h expected %0h",
                                 tag, first, got[first], exp[first]);
        chk({tag, "_bytes_bad"}, 64'(bad), 64'd0);
        if (got.size() == 290) chk({tag, "_csum"}, 64'(got[289]), 64'hEB);
        chk({tag, "_stall_viol"}, 64'(stall_viol), 64'd0);
        chk({tag, "_rdreg_bad"}, 64'(rdreg_bad), 64'd0);
    endtask

    task automatic do_start(output int t);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = cyc;
        chk("hdr_valid", 64'(tx_valid), 64'd1);
        chk("hdr_data", 64'(tx_data), 64'hA5);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) seen = 1;
            n++;
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic clear_obs();
        got.delete();
        done_count = 0;
        stall_viol = 0;
        rdreg_bad  = 0;
    endtask

    initial begin
        int t;
        int n;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[5] = 64'hDEADBEEF_CAFEF00D;
        build_exp();
        reset = 1'b0;
        start = 1'b1;
        tx_ready = 1'b1;

        // Reset with start and tx_ready asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_reg", 64'(rd_reg), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        reset = 1'b1;
        start = 1'b0;
        chk("rst_no_bytes", 64'(got.size()), 64'd0);

        // Full back-to-back dump
        clear_obs();
        do_start(t);
        wait_done(400);
        check_frame("full");
        chk("full_done_latency", 64'(done_cyc - t), 64'd290);
        chk("full_done_after_last", 64'(done_cyc - last_hs_cyc), 64'd1);
        chk("full_done_count", 64'(done_count), 64'd1);

        // Random backpressure with a long stall on byte 3
        clear_obs();
        hold_done = 0;
        hold_left = 0;
        mode = 1;
        do_start(t);
        wait_done(3000);
        mode = 0;
        check_frame("bp");
        chk("bp_done_count", 64'(done_count), 64'd1);

        // Write x7 right after its index handshake; stream must carry the old value
        clear_obs();
        snap_arm = 1;
        do_start(t);
        wait_done(400);
        check_frame("snap");
        rf[7] = '0;

        // start pulses during DATA and in DONE are ignored
        clear_obs();
        do_start(t);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ign_busy_mid", 64'(busy), 64'd1);
        wait_done(400);
        chk("ign_busy_on_done", 64'(busy), 64'd0);
        chk("ign_valid_on_done", 64'(tx_valid), 64'd0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("ign_len", 64'(got.size()), 64'd290);
        chk("ign_done_count", 64'(done_count), 64'd1);
        chk("ign_busy_after", 64'(busy), 64'd0);

        // Reset at byte 100 abandons the frame
        clear_obs();
        do_start(t);
        n = 0;
        while (got.size() < 100 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached_100", 64'(got.size() >= 100), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx_valid", 64'(tx_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rd_reg", 64'(rd_reg), 64'd0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_count), 64'd0);

        clear_obs();
        do_start(t);
        wait_done(400);
        check_frame("fresh");
        if (got.size() > 1) chk("fresh_idx0", 64'(got[1]), 64'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_dump_64.md
# regfile_dump_64

Debug read-out engine for the 64-bit, 32-entry integer register file. On a start pulse it walks every architectural register through a register-file read port and serializes the contents as a framed byte stream (header, per-register index + 8 data bytes, XOR checksum) over a valid/ready interface. It sits beside the core's decode stage, owns one read port while busy, and feeds the debug UART/trace path.

## Interface
Parameters:
- NUM_REGS, 32: registers dumped, indices 0..NUM_REGS-1 (max 32).
- DATA_W, 64: register width; multiple of 8; bytes per register = DATA_W/8.
- HDR_BYTE, 8'hA5: frame header byte.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- start  in  1  request a dump; honoured only in IDLE.
- rd_reg  out  5  register index driven to the register-file read port.
- rd_data  in  DATA_W  combinational read data for rd_reg.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts byte; handshake = tx_valid && tx_ready.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse at end of a completed dump.

## Operation
- States: IDLE, HDR, IDX, DATA, CSUM, DONE.
- IDLE: tx_valid=0, busy=0, rd_reg=0. start=1 -> HDR; reg index cleared to 0, checksum cleared to 0.
- HDR: tx_data=HDR_BYTE. Handshake -> IDX.
- IDX: rd_reg=current index, tx_data={3'b0, index}. On handshake: snapshot rd_data into DATA_W shift register, checksum ^= index byte, byte counter=0 -> DATA.
- DATA: tx_data = snapshot[7:0] (LSB first). On handshake: checksum ^= byte, shift right 8, counter++. After byte DATA_W/8-1: if index==NUM_REGS-1 -> CSUM, else index++ -> IDX.
- CSUM: tx_data=checksum (XOR of all index and data bytes; header excluded). Handshake -> DONE.
- DONE: done=1, busy=0, tx_valid=0 for exactly one cycle -> IDLE.
- busy=1 in HDR, IDX, DATA, CSUM.
- Frame length: 2 + NUM_REGS*(1+DATA_W/8) bytes; 290 at defaults.
- Register value is the value on rd_data in the IDX handshake cycle; later register-file writes to that index do not affect the emitted bytes. x0 emits as read (zero).
- start outside IDLE (including DONE) is ignored; not queued.

## Timing
- Reset (reset=0 at a posedge): next cycle state IDLE, tx_valid=0, tx_data=0, rd_reg=0, busy=0, done=0, index/counter/checksum=0. Reset mid-dump aborts with no done pulse; partial frame is abandoned.
- start sampled at edge t -> tx_valid=1 with HDR_BYTE from cycle t+1.
- Stream rule: once tx_valid=1, tx_valid and tx_data hold stable until handshake; tx_valid never drops without a handshake (except reset).
- One byte per cycle max; tx_ready held 1 gives back-to-back bytes, full frame in 290 cycles, done in cycle 291 after start edge, new start accepted in 292.
- tx_ready ignored when tx_valid=0.
- rd_reg is registered; stable for the whole IDX state; rd_data must settle combinationally within that cycle.

## Test plan
- Reset: drive reset=0 two cycles with start=1, tx_ready=1 -> tx_valid, busy, done, rd_reg, tx_data all 0; no bytes emitted.
- Full dump, tx_ready=1, x5=64'hDEADBEEF_CAFEF00D, all others 0 -> 290 bytes: A5, 00, eight 00, 01, ..., 05, 0D F0 FE CA EF BE AD DE, ..., 1F, eight 00, checksum EB; done one cycle after EB handshake.
- Backpressure: same load, tx_ready random 50% plus held 0 for 6 cycles on byte 3 -> identical 290-byte sequence, tx_data/tx_valid stable while stalled, no drop or duplicate.
- Snapshot: after IDX handshake for index 7, write x7=64'h1 in register file; previously x7=64'h0 -> eight 00 data bytes emitted for reg 7.
- start pulsed during DATA and in DONE -> ignored; exactly one frame emitted, busy falls on done cycle.
- Reset at byte 100 -> next cycle tx_valid=0, busy=0, no done; subsequent start yields fresh frame starting A5, 00.
